// File: rtl/slurm16_memory_arbiter_pkg.sv
// slurm16_memory_arbiter_pkg: shared state enum, default widths and index-width helper
package slurm16_arbiter_pkg;

    localparam int DEF_BITS         = 16;
    localparam int DEF_ADDRESS_BITS = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    // Width of a master index; never zero so a single-master build still has a 1-bit owner
    function automatic int arb_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slurm16_memory_arbiter_if.sv
// slurm16_memory_arbiter_if: bundled master request/response and memory port signals
//   slave  modport: arbiter side (takes master requests, drives memory)
//   master modport: environment side (masters plus memory model)
interface slurm16_memory_arbiter_if
    import slurm16_arbiter_pkg::*;
#(
    parameter int BITS         = DEF_BITS,
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int N_MASTERS    = 4
);

    logic [N_MASTERS*ADDRESS_BITS-1:0] m_address;
    logic [N_MASTERS*BITS-1:0]         m_data_out;
    logic [N_MASTERS-1:0]              m_valid;
    logic [N_MASTERS-1:0]              m_wr;
    logic [N_MASTERS-1:0]              m_ready;
    logic [N_MASTERS-1:0]              m_rvalid;
    logic [BITS-1:0]                   m_data_in;
    logic [ADDRESS_BITS-1:0]           mem_address;
    logic [BITS-1:0]                   mem_data_out;
    logic                              mem_en;
    logic                              mem_wr;
    logic [BITS-1:0]                   mem_data_in;

    modport slave (
        input  m_address, m_data_out, m_valid, m_wr, mem_data_in,
        output m_ready, m_rvalid, m_data_in, mem_address, mem_data_out, mem_en, mem_wr
    );

    modport master (
        output m_address, m_data_out, m_valid, m_wr, mem_data_in,
        input  m_ready, m_rvalid, m_data_in, mem_address, mem_data_out, mem_en, mem_wr
    );

endinterface

// File: rtl/slurm16_memory_arbiter_rr_picker.sv
// slurm16_rr_picker: combinational rotating-priority encoder
//   i_req   request vector
//   i_start first index examined; later indices follow modulo N
//   i_excl  mask of masters that may not win
//   o_idx   winning index, o_found high when any unmasked request exists
module slurm16_rr_picker
    import slurm16_arbiter_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = arb_clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    input  logic [N-1:0] i_excl,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    logic [W-1:0] w_j;

    // Scan from the farthest position back so the nearest candidate is the last to write
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = W'((int'(i_start) + k) % N);
            if (i_req[w_j] && !i_excl[w_j]) begin
                o_idx   = w_j;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// slurm16_memory_arbiter: round-robin N-master arbiter onto one synchronous-read memory port
//   CLK, RST  clock and asynchronous active-high reset
//   bus       slurm16_memory_arbiter_if.slave: per-master address/data/valid/wr in,
//             ready/rvalid and shared read data out, single memory port out
//   Macro SLURM16_ARB_CPU_PRIORITY_EN: master 0 wins every arbitration point it requests at
module slurm16_memory_arbiter
    import slurm16_arbiter_pkg::*;
#(
    parameter int BITS         = DEF_BITS,
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int N_MASTERS    = 4,
    parameter int BURST_MAX    = 8
) (
    input logic                    CLK,
    input logic                    RST,
    slurm16_memory_arbiter_if.slave bus
);

    localparam int             OW    = arb_clog2(N_MASTERS);
    localparam int             CW    = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0]  BLAST = CW'(BURST_MAX - 1);

    arb_state_t           r_state;
    logic [OW-1:0]        r_owner;
    logic [OW-1:0]        r_last_owner;
    logic [CW-1:0]        r_burst_cnt;
    logic [N_MASTERS-1:0] r_rd_pending;

    logic [ADDRESS_BITS-1:0] w_addr [N_MASTERS];
    logic [BITS-1:0]         w_data [N_MASTERS];
    logic [N_MASTERS-1:0]    w_owner_oh, w_excl;
    logic [OW-1:0]           w_base, w_start, w_pick, w_win;
    logic                    w_owned, w_accept, w_others, w_forced, w_release, w_found, w_win_found;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
        assign w_addr[i] = bus.m_address[i*ADDRESS_BITS +: ADDRESS_BITS];
        assign w_data[i] = bus.m_data_out[i*BITS +: BITS];
    end

    assign w_owner_oh = N_MASTERS'(1) << r_owner;
    assign w_owned    = r_state == ARB_OWNED;
    assign w_accept   = w_owned & bus.m_valid[r_owner];
    assign w_others   = |(bus.m_valid & ~w_owner_oh);
    // Last access of a full burst while someone else waits: hand over right after it
    assign w_forced   = w_accept & (r_burst_cnt == BLAST) & w_others;
    assign w_release  = w_owned & (~bus.m_valid[r_owner] | w_forced);
    // While owned, the owner is about to become last_owner, so rotation starts after it
    assign w_base     = w_owned ? r_owner : r_last_owner;
    assign w_start    = OW'((int'(w_base) + 1) % N_MASTERS);
    assign w_excl     = w_forced ? w_owner_oh : '0;

    slurm16_rr_picker #(.N(N_MASTERS)) u_picker (
        .i_req   (bus.m_valid),
        .i_start (w_start),
        .i_excl  (w_excl),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

`ifdef SLURM16_ARB_CPU_PRIORITY_EN
    logic w_cpu;
    assign w_cpu       = bus.m_valid[0] & ~w_excl[0];
    assign w_win       = w_cpu ? '0 : w_pick;
    assign w_win_found = w_cpu | w_found;
`else
    assign w_win       = w_pick;
    assign w_win_found = w_found;
`endif

    assign bus.mem_address  = w_addr[r_owner];
    assign bus.mem_data_out = w_data[r_owner];
    assign bus.mem_en       = w_accept;
    assign bus.mem_wr       = w_accept & bus.m_wr[r_owner];
    assign bus.m_ready      = w_accept ? w_owner_oh : '0;
    assign bus.m_rvalid     = r_rd_pending;
    assign bus.m_data_in    = bus.mem_data_in;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ARB_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(N_MASTERS - 1);
            r_burst_cnt  <= '0;
            r_rd_pending <= '0;
        end else begin
            r_rd_pending <= (w_accept & ~bus.m_wr[r_owner]) ? w_owner_oh : '0;
            if (!w_owned) begin
                if (w_win_found) begin
                    r_state     <= ARB_OWNED;
                    r_owner     <= w_win;
                    r_burst_cnt <= '0;
                end
            end else if (w_release) begin
                r_last_owner <= r_owner;
                if (w_win_found) begin
                    r_owner     <= w_win;
                    r_burst_cnt <= '0;
                end else begin
                    r_state <= ARB_IDLE;
                end
            end else if (w_accept && r_burst_cnt != BLAST) begin
                // Saturates so a lone owner keeps streaming until someone else asks
                r_burst_cnt <= r_burst_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// tb_slurm16_memory_arbiter: vector table, directed corner sequences and randomized model check
module tb_slurm16_memory_arbiter;
    import slurm16_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int B  = 16;
    localparam int A  = 16;
    localparam int BM = 8;
`ifdef SLURM16_ARB_CPU_PRIORITY_EN
    localparam bit CPU_PRI = 1'b1;
`else
    localparam bit CPU_PRI = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    slurm16_memory_arbiter_if #(.BITS(B), .ADDRESS_BITS(A), .N_MASTERS(N)) bus ();

    slurm16_memory_arbiter #(.BITS(B), .ADDRESS_BITS(A), .N_MASTERS(N), .BURST_MAX(BM)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [A-1:0] addr [N];
    logic [B-1:0] wdat [N];
    logic [N-1:0] valid, wr_v;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.m_address[i*A +: A]  = addr[i];
            bus.m_data_out[i*B +: B] = wdat[i];
        end
    end
    assign bus.m_valid = valid;
    assign bus.m_wr    = wr_v;

    logic [B-1:0] mem [0:65535];
    logic         ld = 1'b0;
    logic [A-1:0] ld_a;
    logic [B-1:0] ld_d;

    always @(posedge CLK) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (bus.mem_en) begin
            if (bus.mem_wr) mem[bus.mem_address] <= bus.mem_data_out;
            else bus.mem_data_in <= mem[bus.mem_address];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [A-1:0] a, input logic [B-1:0] d);
        @(negedge CLK);
        ld   = 1'b1;
        ld_a = a;
        ld_d = d;
        @(negedge CLK);
        ld = 1'b0;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        valid = '0;
        wr_v  = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic cyc(input logic [N-1:0] v);
        @(negedge CLK);
        valid = v;
        #1;
    endtask

    typedef struct {
        logic [N-1:0] v, w;
        logic [A-1:0] a;
        logic [B-1:0] d;
        logic [N-1:0] rdy, rv;
        logic         en, mw;
        logic [B-1:0] dat;
    } vec_t;
    vec_t tbl [9];

    // Reference model state: holder -1 means nobody holds the grant
    int           holder, prev, run;
    logic [N-1:0] m_rv;
    logic [B-1:0] m_dat;
    logic [B-1:0] ref_mem [64];
    logic [N-1:0] pend;

    function automatic int pick(input logic [N-1:0] v, input int after, input int excl);
        if (CPU_PRI && v[0] && excl != 0) return 0;
        for (int k = 1; k <= N; k++) begin
            int i = (after + k) % N;
            if (v[i] && i != excl) return i;
        end
        return -1;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e, pe, er;
        logic [B-1:0] ed;
        tbl[0] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{4'b0001, 4'b0000, 16'h1234, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{4'b0001, 4'b0000, 16'h1234, 16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
        tbl[3] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'hBEEF};
        tbl[4] = '{4'b0100, 4'b0100, 16'h0040, 16'h00FF, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{4'b0100, 4'b0100, 16'h0040, 16'h00FF, 4'b0100, 4'b0000, 1'b1, 1'b1, 16'h0000};
        tbl[6] = '{4'b0001, 4'b0000, 16'h0040, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[7] = '{4'b0001, 4'b0000, 16'h0040, 16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
        tbl[8] = '{4'b0000, 4'b0000, 16'h0040, 16'h0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'h00FF};

        valid = '0;
        wr_v  = 4'hF;
        for (int i = 0; i < N; i++) begin
            addr[i] = 16'hA000 + A'(i);
            wdat[i] = '0;
        end
        RST = 1'b1;
        load(16'h1234, 16'hBEEF);
        load(16'h0100, 16'h1111);
        load(16'h0101, 16'h2222);
        load(16'h0102, 16'h3333);
        #1;
        chk("rst_ready", bus.m_ready, 0);
        chk("rst_rvalid", bus.m_rvalid, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_address, 16'hA000);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            valid = tbl[i].v;
            wr_v  = tbl[i].w;
            for (int m = 0; m < N; m++) begin
                addr[m] = tbl[i].a;
                wdat[m] = tbl[i].d;
            end
            #1;
            chk($sformatf("tbl%0d_ready", i), bus.m_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_rvalid", i), bus.m_rvalid, tbl[i].rv);
            chk($sformatf("tbl%0d_mem_en", i), bus.mem_en, tbl[i].en);
            chk($sformatf("tbl%0d_mem_wr", i), bus.mem_wr, tbl[i].mw);
            if (tbl[i].en) chk($sformatf("tbl%0d_mem_addr", i), bus.mem_address, tbl[i].a);
            if (tbl[i].rv != 0) chk($sformatf("tbl%0d_rdata", i), bus.m_data_in, tbl[i].dat);
        end

        // Contention: masters 0 and 2 alternate in bursts of BM with no idle cycles
        do_reset();
        addr[0] = 16'h0010;
        addr[2] = 16'h0020;
        pe = '0;
        for (int c = 0; c < 41; c++) begin
            cyc(4'b0101);
            e = (c == 0) ? 4'b0000 : ((((c - 1) / BM) % 2 == 0) ? 4'b0001 : 4'b0100);
            chk($sformatf("cont%0d_ready", c), bus.m_ready, e);
            chk($sformatf("cont%0d_rvalid", c), bus.m_rvalid, pe);
            pe = e;
        end

        // Release: master 1 does three reads then drops, master 3 waiting takes over
        do_reset();
        addr[1] = 16'h0100;
        addr[3] = 16'h0200;
        cyc(4'b1010);
        chk("rel_idle_ready", bus.m_ready, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1010);
            addr[1] = 16'h0100 + A'(k);
            #1;
            chk($sformatf("rel_acc%0d_ready", k), bus.m_ready, 4'b0010);
            chk($sformatf("rel_acc%0d_addr", k), bus.mem_address, 16'h0100 + A'(k));
            if (k > 0) chk($sformatf("rel_rd%0d", k), bus.m_data_in, k == 1 ? 16'h1111 : 16'h2222);
        end
        cyc(4'b1000);
        chk("rel_drop_ready", bus.m_ready, 0);
        chk("rel_last_rvalid", bus.m_rvalid, 4'b0010);
        chk("rel_last_rdata", bus.m_data_in, 16'h3333);
        cyc(4'b1000);
        chk("rel_m3_ready", bus.m_ready, 4'b1000);
        cyc(4'b0000);
        chk("rel_m3_rvalid", bus.m_rvalid, 4'b1000);

        // Reset during master 1's fourth access with a read pending
        do_reset();
        addr[1] = 16'h0100;
        for (int k = 0; k < 5; k++) cyc(4'b0010);
        chk("rmb_ready", bus.m_ready, 4'b0010);
        chk("rmb_rvalid", bus.m_rvalid, 4'b0010);
        RST = 1'b1;
        #1;
        chk("rmb_rst_ready", bus.m_ready, 0);
        chk("rmb_rst_rvalid", bus.m_rvalid, 0);
        chk("rmb_rst_mem_en", bus.mem_en, 0);
        @(negedge CLK);
        RST = 1'b0;
        valid = 4'b0011;
        #1;
        chk("rmb_idle_ready", bus.m_ready, 0);
        cyc(4'b0011);
        chk("rmb_first_ready", bus.m_ready, 4'b0001);

        // Arbitration from IDLE with last_owner = 0 and masters 0, 1, 3 requesting
        do_reset();
        cyc(4'b0001);
        cyc(4'b0001);
        chk("pri_setup_ready", bus.m_ready, 4'b0001);
        cyc(4'b0000);
        cyc(4'b1011);
        chk("pri_idle_ready", bus.m_ready, 0);
        cyc(4'b1011);
        chk("pri_grant", bus.m_ready, CPU_PRI ? 4'b0001 : 4'b0010);

        // Randomized traffic against the reference model
        RST   = 1'b1;
        valid = '0;
        wr_v  = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            ld   = 1'b1;
            ld_a = A'(i);
            ld_d = B'($urandom);
            ref_mem[i] = ld_d;
        end
        @(negedge CLK);
        ld  = 1'b0;
        RST = 1'b0;
        holder = -1;
        prev   = N - 1;
        run    = 0;
        m_rv   = '0;
        m_dat  = '0;
        pend   = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[i] = 1'b1;
                        addr[i] = A'($urandom_range(63, 0));
                        wdat[i] = B'($urandom);
                        wr_v[i] = 1'($urandom_range(1, 0));
                    end
                end else if ($urandom_range(15, 0) == 0) pend[i] = 1'b0;
            end
            valid = pend;
            #1;
            er = '0;
            e  = m_rv;
            ed = m_dat;
            m_rv = '0;
            if (holder < 0) begin
                if (valid != 0) begin
                    holder = pick(valid, prev, -1);
                    run    = 0;
                end
            end else if (valid[holder]) begin
                er[holder] = 1'b1;
                if (wr_v[holder]) ref_mem[addr[holder][5:0]] = wdat[holder];
                else begin
                    m_rv[holder] = 1'b1;
                    m_dat = ref_mem[addr[holder][5:0]];
                end
                run++;
                if (run >= BM && (valid & ~(N'(1) << holder)) != 0) begin
                    prev   = holder;
                    holder = pick(valid, holder, holder);
                    run    = 0;
                end
            end else begin
                prev   = holder;
                holder = pick(valid, holder, -1);
                run    = 0;
            end
            chk($sformatf("rnd%0d_ready", c), bus.m_ready, er);
            chk($sformatf("rnd%0d_rvalid", c), bus.m_rvalid, e);
            if (e != 0) chk($sformatf("rnd%0d_rdata", c), bus.m_data_in, ed);
            pend = pend & ~er;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
